// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX line among NUM_REQ byte requesters, one frame per grant.
// Define UART_ARB_PARITY_EN to insert an even-parity bit between the payload and the stop bits.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                         clk_in,
  input  logic                         nrst_in,
  input  logic                         baudpulse_in,
  input  logic [NUM_REQ-1:0]           req_in,
  input  logic [NUM_REQ*DATA_BITS-1:0] data_in,
  output logic [NUM_REQ-1:0]           gnt_out,
  output logic [$clog2(NUM_REQ)-1:0]   owner_out,
  output logic                         busy_out,
  output logic                         tx_out
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [IDX_W:0]   C_NREQ      = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] C_LAST_REQ  = IDX_W'(NUM_REQ-1);
  localparam logic [BIT_W-1:0] C_LAST_BIT  = BIT_W'(DATA_BITS-1);
  localparam logic             C_LAST_STOP = 1'(STOP_BITS-1);

`ifdef UART_ARB_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                 r_state, w_state_nxt;
  logic                   r_tx, w_tx_nxt;
  logic                   r_busy, w_busy_nxt;
  logic [NUM_REQ-1:0]     r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0]       r_owner, w_owner_nxt;
  logic [IDX_W-1:0]       r_rr, w_rr_nxt;
  logic [BIT_W-1:0]       r_bit_cnt, w_bit_nxt;
  logic                   r_stop_cnt, w_stop_nxt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   w_load, w_shift;
  logic                   w_found;
  logic [IDX_W-1:0]       w_winner;
  logic [IDX_W:0]         w_cand;
  logic [DATA_BITS-1:0]   w_byte;
`ifdef UART_ARB_PARITY_EN
  logic                   r_par;
`endif

  // Search from the rr pointer downwards in priority; scanning backwards lets the nearest hit win.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      w_cand = (IDX_W+1)'(r_rr) + (IDX_W+1)'(k);
      if (w_cand >= C_NREQ) w_cand = w_cand - C_NREQ;
      if (req_in[w_cand[IDX_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[IDX_W-1:0];
      end
    end
  end

  assign w_byte = data_in[w_winner*DATA_BITS +: DATA_BITS];

  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_gnt_nxt   = '0;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr;
    w_bit_nxt   = r_bit_cnt;
    w_stop_nxt  = r_stop_cnt;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_nxt[w_winner] = 1'b1;
          w_owner_nxt         = w_winner;
          w_busy_nxt          = 1'b1;
          w_load              = 1'b1;
          w_rr_nxt            = (w_winner == C_LAST_REQ) ? '0 : w_winner + 1'b1;
          w_state_nxt         = S_ALIGN;
        end
      end
      // The grant edge is spent in IDLE, so a pulse coinciding with it never reaches here.
      S_ALIGN: begin
        if (baudpulse_in) begin
          w_tx_nxt    = 1'b0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (baudpulse_in) begin
          w_tx_nxt    = r_shift[0];
          w_shift     = 1'b1;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (baudpulse_in) begin
          if (r_bit_cnt == C_LAST_BIT) begin
`ifdef UART_ARB_PARITY_EN
            w_tx_nxt    = r_par;
            w_state_nxt = S_PARITY;
`else
            w_tx_nxt    = 1'b1;
            w_stop_nxt  = 1'b0;
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_tx_nxt  = r_shift[0];
            w_shift   = 1'b1;
            w_bit_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
`ifdef UART_ARB_PARITY_EN
      S_PARITY: begin
        if (baudpulse_in) begin
          w_tx_nxt    = 1'b1;
          w_stop_nxt  = 1'b0;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (baudpulse_in) begin
          if (r_stop_cnt == C_LAST_STOP) begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_stop_nxt = r_stop_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      r_state    <= S_IDLE;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_gnt      <= '0;
      r_owner    <= '0;
      r_rr       <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= w_busy_nxt;
      r_gnt      <= w_gnt_nxt;
      r_owner    <= w_owner_nxt;
      r_rr       <= w_rr_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_stop_cnt <= w_stop_nxt;
    end
  end

  // Payload path carries no reset; it is always loaded before it is shifted out.
  always_ff @(posedge clk_in) begin
    if (w_load) begin
      r_shift <= w_byte;
    end else if (w_shift) begin
      r_shift <= r_shift >> 1;
    end
  end

`ifdef UART_ARB_PARITY_EN
  always_ff @(posedge clk_in) begin
    if (w_load) r_par <= ^w_byte;
  end
`endif

  assign tx_out    = r_tx;
  assign busy_out  = r_busy;
  assign gnt_out   = r_gnt;
  assign owner_out = r_owner;

endmodule
